// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall control and the IF/ID
// pipeline register feeding decode, plus a sticky flag for misaligned redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignErr
);

  logic [31:0] pc_plus4_f;

  assign pc_plus4_f = PCF + 32'd4;

  // Redirect beats stall so a taken branch is never dropped; low target bits are
  // forced to zero and the misalignment is reported separately.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= {PCTargetE[31:2], 2'b00};
    end else if (!StallF) begin
      PCF <= pc_plus4_f;
    end
  end

  // Flush beats stall: a bubble is inserted even while decode is held.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MisalignErr <= 1'b0;
    end else if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      MisalignErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a combinational instruction memory derived from
// the fetch address, hand-computed expectations per edge, one summary line.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        MisalignErr;

  int checks;
  int failures;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .MisalignErr(MisalignErr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  assign InstrF = imem(PCF);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic src, input logic [31:0] tgt,
                       input logic sf, input logic sd, input logic fd);
    reset     = rst;
    PCSrcE    = src;
    PCTargetE = tgt;
    StallF    = sf;
    StallD    = sd;
    FlushD    = fd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_instrd"}, InstrD, NOP);
    check({tag, "_pcd"}, PCD, 32'h0);
    check({tag, "_pcplus4d"}, PCPlus4D, 32'h0);
    check({tag, "_validd"}, {31'd0, ValidD}, 32'd0);
  endtask

  task automatic check_decode(input string tag, input logic [31:0] pc);
    check({tag, "_instrd"}, InstrD, imem(pc));
    check({tag, "_pcd"}, PCD, pc);
    check({tag, "_pcplus4d"}, PCPlus4D, pc + 32'd4);
    check({tag, "_validd"}, {31'd0, ValidD}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // reset state
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_pcf", PCF, 32'h0);
    check_bubble("rst");
    check("rst_misalign", {31'd0, MisalignErr}, 32'd0);

    // sequential run: PCF 4,8,C,10 with decode trailing by one
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pcf", PCF, 32'(4 * i));
      check_decode("seq", 32'(4 * (i - 1)));
    end

    // no combinational path into PCF
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    #1;
    check("comb_pcf", PCF, 32'h10);

    // redirect with external flush at PCF=0x10
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    tick();
    check("redir_pcf", PCF, 32'h100);
    check_bubble("redir");
    idle();
    tick();
    check("redir2_pcf", PCF, 32'h104);
    check_decode("redir2", 32'h100);
    check("redir2_misalign", {31'd0, MisalignErr}, 32'd0);

    // load-use stall at PCF=0x8
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check("pre_stall_pcf", PCF, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_pcf", PCF, 32'h8);
      check_decode("stall", 32'h4);
    end
    idle();
    tick();
    check("unstall_pcf", PCF, 32'hC);
    check_decode("unstall", 32'h8);

    // everything at once: redirect beats stall, flush beats stall
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b1);
    tick();
    check("simul_pcf", PCF, 32'h40);
    check_bubble("simul");

    // StallF only: duplicate fetch of the same PC
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("dup1_pcf", PCF, 32'h40);
    check_decode("dup1", 32'h40);
    tick();
    check("dup2_pcf", PCF, 32'h40);
    check_decode("dup2", 32'h40);

    // StallD only: PC advances, decode holds
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check("sd_pcf", PCF, 32'h44);
    check_decode("sd", 32'h40);
    idle();
    tick();
    check("sd2_pcf", PCF, 32'h48);
    check_decode("sd2", 32'h44);

    // misaligned target
    drive(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0, 1'b0);
    tick();
    check("mis_pcf", PCF, 32'h100);
    check("mis_flag", {31'd0, MisalignErr}, 32'd1);
    idle();
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("mis_sticky", {31'd0, MisalignErr}, 32'd1);
    end
    check("mis_run_pcf", PCF, 32'h128);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("mis_rst", {31'd0, MisalignErr}, 32'd0);

    // wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick();
    check("wrap0_pcf", PCF, 32'hFFFF_FFFC);
    idle();
    tick();
    check("wrap_pcf", PCF, 32'h0);
    check("wrap_pcd", PCD, 32'hFFFF_FFFC);
    check("wrap_pcplus4d", PCPlus4D, 32'h0);
    check("wrap_instrd", InstrD, imem(32'hFFFF_FFFC));

    // reset during a redirect discards the redirect
    drive(1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1);
    tick();
    check("midrst_pcf", PCF, 32'h0);
    check_bubble("midrst");
    idle();
    tick();
    check("postrst_pcf", PCF, 32'h4);
    check_decode("postrst", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
